// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding valid/ready transaction with a fixed
// access latency, byte-strobed writes and misaligned/out-of-range error reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W-3:0] WORD_LIM = (ADDR_W-2)'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Out-of-range word indices are rejected outright, never wrapped.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        addr_err = (a[1:0] != 2'b00) || (a[ADDR_W-1:2] >= WORD_LIM);
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               accept_s;
    logic               commit_s;
    logic               we_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [31:0]        wdata_r;
    logic [3:0]         wstrb_r;
    logic               err_s;
    logic [IDX_W-1:0]   idx_s;
    logic               rsp_valid_r;
    logic [31:0]        rsp_rdata_r;
    logic               rsp_err_r;
    logic [31:0]        mem [DEPTH_WORDS];

    assign req_ready = (state_r == ST_IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign err_s     = addr_err(addr_r);
    assign idx_s     = addr_r[IDX_W+1:2];

    // Next-state decode; the WAIT counter expires at zero so that the commit
    // edge lands exactly LATENCY edges after acceptance.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = CNT_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    commit_s    = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Control state, request capture and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= 32'h0000_0000;
            wstrb_r     <= 4'b0000;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (accept_s) begin
                we_r    <= req_we;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                wstrb_r <= req_wstrb;
            end
            if (commit_s) begin
                rsp_valid_r <= 1'b1;
                if (err_s) begin
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_err_r   <= 1'b1;
                end else if (we_r) begin
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_err_r   <= 1'b0;
                end else begin
                    rsp_rdata_r <= mem[idx_s];
                    rsp_err_r   <= 1'b0;
                end
            end else if ((state_r == ST_RESP) && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    // Array write on the commit edge; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (commit_s && we_r && !err_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_r[b]) begin
                    mem[idx_s][8*b +: 8] <= wdata_r[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for function, backpressure
// and reset cases, plus a LATENCY=1 instance for the short-latency path.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        req_valid1, rsp_ready1, req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;

    int checks;
    int failures;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .ADDR_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    always #5 clk = ~clk;

    // One full transaction on the LATENCY=2 instance; lat = edges from acceptance to rsp_valid.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid) lat = -1;
        rdata = rsp_rdata; err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // Same transaction sequence on the LATENCY=1 instance.
    task automatic do_txn1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic [31:0] rdata,
                           output logic err, output int lat);
        int n;
        n = 0;
        while (!req_ready1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        lat = 0;
        while (!rsp_valid1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid1) lat = -1;
        rdata = rsp_rdata1; err = rsp_err1;
        rsp_ready1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready1 = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b ready=%b rdata=%h err=%b required 0 1 00000000 0",
                     rsp_valid, req_ready, rsp_rdata, rsp_err);
        end
        checks++;
        if (rsp_valid1 !== 1'b0 || req_ready1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_state_l1: got valid=%b ready=%b required 0 1", rsp_valid1, req_ready1);
        end
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        checks++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
            failures++;
            $display("FAIL write_resp: got lat=%0d rdata=%h err=%b required 2 00000000 0", lat, rd, er);
        end
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            failures++;
            $display("FAIL read_resp: got lat=%0d rdata=%h err=%b required 2 deadbeef 0", lat, rd, er);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd, er, lat);
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADAAEF || er !== 1'b0) begin
            failures++;
            $display("FAIL byte_strobe: got rdata=%h err=%b required deadaaef 0", rd, er);
        end
        do_txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== 2) begin
            failures++;
            $display("FAIL zero_strobe_resp: got lat=%0d rdata=%h err=%b required 2 00000000 0", lat, rd, er);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_read: got rdata=%h err=%b required 00000000 1", rd, er);
        end
        do_txn(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_write: got rdata=%h err=%b required 00000000 1", rd, er);
        end
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADAAEF || er !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_no_write: got rdata=%h err=%b required deadaaef 0", rd, er);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b1, 32'h0, 32'h0, 4'hF, rd, er, lat);
        do_txn(1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            failures++;
            $display("FAIL oor_write: got rdata=%h err=%b required 00000000 1", rd, er);
        end
        do_txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            failures++;
            $display("FAIL oor_no_alias: got rdata=%h err=%b required 00000000 0", rd, er);
        end
        do_txn(1'b0, 32'h0FFC, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (er !== 1'b0) begin
            failures++;
            $display("FAIL last_word_legal: got err=%b required 0", er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'h0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'hF;
        req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADAAEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b required 1 deadaaef 0 0",
                         c, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_handshake: got valid=%b ready=%b required 0 1", rsp_valid, req_ready);
        end
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADAAEF) begin
            failures++;
            $display("FAIL ignored_request: got rdata=%h required deadaaef", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b1, 32'h20, 32'h00000001, 4'hF, rd, er, lat);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL in_wait: got ready=%b valid=%b required 0 0", req_ready, rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: got valid=%b ready=%b required 0 1", rsp_valid, req_ready);
        end
        @(posedge clk); @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;
        do_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h00000001 || er !== 1'b0 || lat !== 2) begin
            failures++;
            $display("FAIL dropped_write: got lat=%0d rdata=%h err=%b required 2 00000001 0", lat, rd, er);
        end
    endtask

    task automatic test_latency1();
        logic [31:0] rd; logic er; int lat;
        do_txn1(1'b1, 32'h4, 32'hCAFEF00D, 4'hF, rd, er, lat);
        checks++;
        if (lat !== 1 || rd !== 32'h0 || er !== 1'b0) begin
            failures++;
            $display("FAIL l1_write: got lat=%0d rdata=%h err=%b required 1 00000000 0", lat, rd, er);
        end
        do_txn1(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (lat !== 1 || rd !== 32'hCAFEF00D || er !== 1'b0) begin
            failures++;
            $display("FAIL l1_read: got lat=%0d rdata=%h err=%b required 1 cafef00d 0", lat, rd, er);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        clk = 1'b0; rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
        rsp_ready = 1'b0; req_valid1 = 1'b0; rsp_ready1 = 1'b0;
        test_reset();
        test_write_read();
        test_strobe();
        test_misaligned();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_latency1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
